// File: rtl/bram_stream_reader.sv
// Streams a run of consecutive BRAM words out as a valid/ready stream.
// A 2-entry output FIFO absorbs the 1-cycle read latency so backpressure never drops or repeats a beat.
module bram_stream_reader #(
    parameter int RAM_WIDTH  = 64,
    parameter int RAM_DEPTH  = 512,
    parameter int LEN_WIDTH  = $clog2(RAM_DEPTH) + 1,
    localparam int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] base_addr_i,
    input  logic [LEN_WIDTH-1:0]  length_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] addr_b_o,
    input  logic [RAM_WIDTH-1:0]  data_b_i,
    output logic [RAM_WIDTH-1:0]  data_o,
    output logic                  valid_o,
    output logic                  last_o,
    input  logic                  ready_i
);

    typedef enum logic {IDLE, READ} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;
    logic                  done_q, done_d;
    logic [RAM_WIDTH-1:0]  data0_q, data0_d, data1_q, data1_d;
    logic                  last0_q, last0_d, last1_q, last1_d;
    logic [1:0]            count_q, count_d;

    logic                  pop;
    logic                  issue;
    logic [2:0]            occupancy;

    assign valid_o  = (count_q != 2'd0);
    assign last_o   = last0_q & valid_o;
    assign data_o   = data0_q;
    assign addr_b_o = addr_q;
    assign busy_o   = (state_q == READ);
    assign done_o   = done_q;

    assign pop       = valid_o & ready_i;
    // Occupancy after this cycle's pop, counting the word still on its way out of the BRAM.
    assign occupancy = 3'(count_q) + 3'(inflight_q) - 3'(pop);
    assign issue     = (state_q == READ) && (remaining_q != '0) && (occupancy < 3'd2);

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        next_addr_d     = next_addr_q;
        remaining_d     = remaining_q;
        inflight_d      = 1'b0;
        inflight_last_d = inflight_last_q;
        done_d          = 1'b0;
        data0_d         = data0_q;
        data1_d         = data1_q;
        last0_d         = last0_q;
        last1_d         = last1_q;
        count_d         = count_q;

        if (pop) begin
            data0_d = data1_q;
            last0_d = last1_q;
            count_d = count_q - 2'd1;
        end
        // The returning word lands in the first free slot once the pop has shifted the head.
        if (inflight_q) begin
            if (count_d == 2'd0) begin
                data0_d = data_b_i;
                last0_d = inflight_last_q;
                count_d = 2'd1;
            end else if (count_d == 2'd1) begin
                data1_d = data_b_i;
                last1_d = inflight_last_q;
                count_d = 2'd2;
            end
        end

        if (issue) begin
            addr_d          = next_addr_q;
            next_addr_d     = (next_addr_q == ADDR_WIDTH'(RAM_DEPTH - 1)) ? '0 : next_addr_q + 1'b1;
            remaining_d     = remaining_q - 1'b1;
            inflight_d      = 1'b1;
            inflight_last_d = (remaining_q == LEN_WIDTH'(1));
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (length_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = READ;
                        next_addr_d = base_addr_i;
                        remaining_d = length_i;
                    end
                end
            end
            READ: begin
                // Abort takes priority over a final handshake in the same cycle.
                if (abort_i) begin
                    state_d     = IDLE;
                    remaining_d = '0;
                    inflight_d  = 1'b0;
                    count_d     = 2'd0;
                end else if (pop && last0_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q         <= IDLE;
            addr_q          <= '0;
            next_addr_q     <= '0;
            remaining_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
            data0_q         <= '0;
            data1_q         <= '0;
            last0_q         <= 1'b0;
            last1_q         <= 1'b0;
            count_q         <= 2'd0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            next_addr_q     <= next_addr_d;
            remaining_q     <= remaining_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            done_q          <= done_d;
            data0_q         <= data0_d;
            data1_q         <= data1_d;
            last0_q         <= last0_d;
            last1_q         <= last1_d;
            count_q         <= count_d;
        end
    end

endmodule
